// File: rtl/bp_me_pkg.sv
// Shared CCE types: processor configuration, microcode instruction layout and
// the instruction-fetch FSM states.
package bp_me_pkg;

    typedef enum logic [0:0] {
        e_bp_default_cfg = 1'b0
    } bp_params_e;

    typedef struct packed {
        logic [7:0]  op;
        logic [7:0]  dst;
        logic [15:0] imm;
    } bp_cce_inst_s;

    typedef enum logic [0:0] {
        e_idle  = 1'b0,
        e_fetch = 1'b1
    } bp_cce_inst_fetch_state_e;

    function automatic int cce_pc_width(input bp_params_e cfg);
        case (cfg)
            e_bp_default_cfg: cce_pc_width = 8;
            default:          cce_pc_width = 8;
        endcase
    endfunction

    function automatic int cce_instr_width(input bp_params_e cfg);
        case (cfg)
            e_bp_default_cfg: cce_instr_width = $bits(bp_cce_inst_s);
            default:          cce_instr_width = $bits(bp_cce_inst_s);
        endcase
    endfunction

endpackage

// File: rtl/bp_cce_inst_fetch_chk.sv
// Protocol checks on the fetch stage's inputs; simulation only.
module bp_cce_inst_fetch_chk (
    input logic clk_i,
    input logic reset_n_i,
    input logic fetching,
    input logic ucode_w_v_i,
    input logic branch_v_i,
    input logic inst_yumi_i,
    input logic inst_v_o
);

    a_branch_needs_yumi: assert property (@(posedge clk_i) disable iff (!reset_n_i)
        branch_v_i |-> inst_yumi_i)
        else $error("branch_v_i asserted without inst_yumi_i");

    a_yumi_needs_valid: assert property (@(posedge clk_i) disable iff (!reset_n_i)
        inst_yumi_i |-> inst_v_o)
        else $error("inst_yumi_i asserted without inst_v_o");

    a_no_write_in_fetch: assert property (@(posedge clk_i) disable iff (!reset_n_i)
        fetching |-> !ucode_w_v_i)
        else $error("ucode_w_v_i asserted while fetching");

endmodule

// File: rtl/bsg_mem_1rw_sync.sv
// Single-port synchronous RAM: one read or one write per cycle, read data
// registered and valid the cycle after the access.
module bsg_mem_1rw_sync #(
    parameter int width_p = 32,
    parameter int els_p   = 256,
    localparam int addr_width_lp = $clog2(els_p)
) (
    input  logic                     clk_i,
    input  logic                     v_i,
    input  logic                     w_i,
    input  logic [addr_width_lp-1:0] addr_i,
    input  logic [width_p-1:0]       data_i,
    output logic [width_p-1:0]       data_o
);

    logic [width_p-1:0] mem_r [els_p];
    logic [width_p-1:0] data_r;

    // Array write or registered read; contents deliberately survive reset.
    always_ff @(posedge clk_i) begin
        if (v_i && w_i) begin
            mem_r[addr_i] <= data_i;
        end else if (v_i) begin
            data_r <= mem_r[addr_i];
        end
    end

    assign data_o = data_r;

endmodule

// File: rtl/bp_cce_inst_fetch.sv
// CCE microcode fetch: instruction RAM loaded while idle, sequential PC with
// branch redirect, and a 2-entry (pc, inst) buffer with bypass of read data.
module bp_cce_inst_fetch
    import bp_me_pkg::*;
#(
    parameter bp_params_e bp_params_p = e_bp_default_cfg,
    localparam int cce_pc_width_p    = cce_pc_width(bp_params_p),
    localparam int cce_instr_width_p = cce_instr_width(bp_params_p)
) (
    input  logic                         clk_i,
    input  logic                         reset_n_i,

    input  logic                         ucode_w_v_i,
    input  logic [cce_pc_width_p-1:0]    ucode_addr_i,
    input  logic [cce_instr_width_p-1:0] ucode_data_i,
    output logic                         ucode_w_ready_o,

    input  logic                         start_i,
    input  logic [cce_pc_width_p-1:0]    start_pc_i,
    input  logic                         halt_i,

    input  logic                         branch_v_i,
    input  logic [cce_pc_width_p-1:0]    branch_target_i,

    output logic                         inst_v_o,
    output logic [cce_pc_width_p-1:0]    pc_o,
    output bp_cce_inst_s                 inst_o,
    input  logic                         inst_yumi_i
);

    bp_cce_inst_fetch_state_e state_r, state_n;

    logic [cce_pc_width_p-1:0] fetch_pc_r, fetch_pc_n;
    logic [cce_pc_width_p-1:0] inflight_pc_r;
    logic                      inflight_r;
    logic [1:0]                cnt_r;
    logic                      wptr_r, rptr_r;
    logic [cce_pc_width_p-1:0] pc_buf_r   [2];
    bp_cce_inst_s              inst_buf_r [2];
    logic                      ready_r;

    logic                         fetching_s, branch_s, flush_s, issue_s;
    logic                         buf_empty_s, push_s, pop_s, write_s;
    logic [1:0]                   credits_used_s;
    logic [cce_instr_width_p-1:0] ram_data_s;
    bp_cce_inst_s                 ram_inst_s;

    assign fetching_s     = (state_r == e_fetch);
    assign branch_s       = fetching_s & branch_v_i & inst_yumi_i;
    assign flush_s        = halt_i | branch_s;
    assign credits_used_s = cnt_r + {1'b0, inflight_r};
    assign issue_s        = fetching_s & ~flush_s & ((credits_used_s < 2'd2) | inst_yumi_i);
    assign write_s        = ~fetching_s & ucode_w_v_i;

    // An empty buffer lets the in-flight read feed the head directly, which
    // is what gives start-to-valid in two cycles and a single branch bubble.
    assign buf_empty_s = (cnt_r == 2'd0);
    assign push_s      = inflight_r & ~flush_s & ~(buf_empty_s & inst_yumi_i);
    assign pop_s       = inst_yumi_i & ~buf_empty_s & ~flush_s;
    assign ram_inst_s  = bp_cce_inst_s'(ram_data_s);

    bsg_mem_1rw_sync #(
        .width_p (cce_instr_width_p),
        .els_p   (2 ** cce_pc_width_p)
    ) inst_ram (
        .clk_i  (clk_i),
        .v_i    (write_s | issue_s),
        .w_i    (write_s),
        .addr_i (write_s ? ucode_addr_i : fetch_pc_r),
        .data_i (ucode_data_i),
        .data_o (ram_data_s)
    );

    // Next FSM state; halt overrides start.
    always_comb begin
        state_n = state_r;
        case (state_r)
            e_idle: begin
                if (halt_i) state_n = e_idle;
                else if (start_i) state_n = e_fetch;
                else state_n = e_idle;
            end
            e_fetch: begin
                if (halt_i) state_n = e_idle;
                else state_n = e_fetch;
            end
            default: state_n = e_idle;
        endcase
    end

    // Next fetch PC: start, branch redirect, sequential advance (wraps).
    always_comb begin
        fetch_pc_n = fetch_pc_r;
        if (~fetching_s & start_i & ~halt_i) begin
            fetch_pc_n = start_pc_i;
        end else if (branch_s & ~halt_i) begin
            fetch_pc_n = branch_target_i;
        end else if (issue_s) begin
            fetch_pc_n = fetch_pc_r + {{(cce_pc_width_p-1){1'b0}}, 1'b1};
        end else begin
            fetch_pc_n = fetch_pc_r;
        end
    end

    // Control state: FSM, PC, in-flight tracking and buffer bookkeeping.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_r       <= e_idle;
            fetch_pc_r    <= '0;
            inflight_r    <= 1'b0;
            inflight_pc_r <= '0;
            cnt_r         <= 2'd0;
            wptr_r        <= 1'b0;
            rptr_r        <= 1'b0;
            ready_r       <= 1'b0;
        end else begin
            state_r       <= state_n;
            fetch_pc_r    <= fetch_pc_n;
            inflight_r    <= issue_s;
            inflight_pc_r <= issue_s ? fetch_pc_r : inflight_pc_r;
            ready_r       <= (state_n == e_idle);
            if (flush_s) begin
                cnt_r  <= 2'd0;
                wptr_r <= 1'b0;
                rptr_r <= 1'b0;
            end else begin
                cnt_r  <= cnt_r + {1'b0, push_s} - {1'b0, pop_s};
                wptr_r <= wptr_r ^ push_s;
                rptr_r <= rptr_r ^ pop_s;
            end
        end
    end

    // Buffer storage, written at the write pointer when read data lands.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            pc_buf_r[0]   <= '0;
            pc_buf_r[1]   <= '0;
            inst_buf_r[0] <= '0;
            inst_buf_r[1] <= '0;
        end else if (push_s) begin
            pc_buf_r[wptr_r]   <= inflight_pc_r;
            inst_buf_r[wptr_r] <= ram_inst_s;
        end
    end

    // Head selection: buffered entry first, else the in-flight read.
    always_comb begin
        pc_o   = pc_buf_r[rptr_r];
        inst_o = inst_buf_r[rptr_r];
        if (buf_empty_s & inflight_r) begin
            pc_o   = inflight_pc_r;
            inst_o = ram_inst_s;
        end else begin
            pc_o   = pc_buf_r[rptr_r];
            inst_o = inst_buf_r[rptr_r];
        end
    end

    assign inst_v_o        = ~buf_empty_s | inflight_r;
    assign ucode_w_ready_o = ready_r;

    bp_cce_inst_fetch_chk chk (
        .clk_i       (clk_i),
        .reset_n_i   (reset_n_i),
        .fetching    (fetching_s),
        .ucode_w_v_i (ucode_w_v_i),
        .branch_v_i  (branch_v_i),
        .inst_yumi_i (inst_yumi_i),
        .inst_v_o    (inst_v_o)
    );

endmodule

// File: tb/tb_bp_cce_inst_fetch.sv
// Directed bench for bp_cce_inst_fetch: inputs driven and outputs sampled on
// the falling edge; expected values are hand-computed constants.
module tb_bp_cce_inst_fetch;
    import bp_me_pkg::*;

    logic         clk;
    logic         reset_n;
    logic         ucode_w_v;
    logic [7:0]   ucode_addr;
    logic [31:0]  ucode_data;
    logic         ucode_w_ready;
    logic         start;
    logic [7:0]   start_pc;
    logic         halt;
    logic         branch_v;
    logic [7:0]   branch_target;
    logic         inst_v;
    logic [7:0]   pc;
    bp_cce_inst_s inst;
    logic         inst_yumi;

    int checks   = 0;
    int failures = 0;

    bp_cce_inst_fetch dut (
        .clk_i           (clk),
        .reset_n_i       (reset_n),
        .ucode_w_v_i     (ucode_w_v),
        .ucode_addr_i    (ucode_addr),
        .ucode_data_i    (ucode_data),
        .ucode_w_ready_o (ucode_w_ready),
        .start_i         (start),
        .start_pc_i      (start_pc),
        .halt_i          (halt),
        .branch_v_i      (branch_v),
        .branch_target_i (branch_target),
        .inst_v_o        (inst_v),
        .pc_o            (pc),
        .inst_o          (inst),
        .inst_yumi_i     (inst_yumi)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic do_halt();
        inst_yumi = 1'b0;
        halt      = 1'b1;
        tick();
        halt = 1'b0;
        check("halt_v", 64'(inst_v), 64'd0);
        check("halt_ready", 64'(ucode_w_ready), 64'd1);
    endtask

    task automatic do_start(input logic [7:0] spc);
        start    = 1'b1;
        start_pc = spc;
        tick();
        start = 1'b0;
        check("start_n1_v", 64'(inst_v), 64'd0);
        check("fetch_ready", 64'(ucode_w_ready), 64'd0);
        tick();
    endtask

    // Take `n` instructions back to back, expecting consecutive PCs from p0
    // and inst = pc except for the two top-of-RAM entries.
    task automatic consume(input int n, input logic [7:0] p0);
        logic [7:0]  p;
        logic [31:0] exp_inst;
        p = p0;
        for (int i = 0; i < n; i++) begin
            exp_inst = (p == 8'hFE) ? 32'h0000_A0FE :
                       (p == 8'hFF) ? 32'h0000_A0FF : {24'd0, p};
            check("stream_v", 64'(inst_v), 64'd1);
            check("stream_pc", 64'(pc), 64'(p));
            check("stream_inst", 64'(inst), 64'(exp_inst));
            inst_yumi = 1'b1;
            tick();
            p = p + 8'd1;
        end
        inst_yumi = 1'b0;
    endtask

    initial begin
        reset_n = 1'b0; ucode_w_v = 1'b0; ucode_addr = 8'd0; ucode_data = 32'd0;
        start = 1'b0; start_pc = 8'd0; halt = 1'b0; branch_v = 1'b0;
        branch_target = 8'd0; inst_yumi = 1'b0;
        tick();
        check("rst_v", 64'(inst_v), 64'd0);
        check("rst_pc", 64'(pc), 64'd0);
        check("rst_inst", 64'(inst), 64'd0);
        check("rst_ready", 64'(ucode_w_ready), 64'd0);
        reset_n = 1'b1;
        tick();
        check("idle_ready", 64'(ucode_w_ready), 64'd1);

        // Load RAM[k]=k plus two marker words at the top of the PC space.
        for (int k = 0; k < 16; k++) begin
            ucode_w_v = 1'b1; ucode_addr = 8'(k); ucode_data = 32'(k);
            tick();
        end
        ucode_addr = 8'hFE; ucode_data = 32'h0000_A0FE; tick();
        ucode_addr = 8'hFF; ucode_data = 32'h0000_A0FF; tick();
        ucode_w_v = 1'b0;

        // Free-run with yumi held: one instruction per cycle from pc 0.
        do_start(8'd0);
        consume(10, 8'd0);
        do_halt();

        // Consumer stall for 10 cycles, then release and branch on pc 5.
        do_start(8'd0);
        for (int i = 0; i < 10; i++) tick();
        check("stall_v", 64'(inst_v), 64'd1);
        check("stall_pc", 64'(pc), 64'd0);
        consume(5, 8'd0);
        check("pre_branch_pc", 64'(pc), 64'd5);
        inst_yumi = 1'b1; branch_v = 1'b1; branch_target = 8'h03;
        tick();
        inst_yumi = 1'b0; branch_v = 1'b0;
        check("branch_bubble_v", 64'(inst_v), 64'd0);
        tick();
        consume(4, 8'd3);
        do_halt();

        // PC wrap from all-ones minus one.
        do_start(8'hFE);
        consume(4, 8'hFE);
        do_halt();

        // Reload RAM[0] in the same cycle as start; the new word must be seen.
        ucode_w_v = 1'b1; ucode_addr = 8'd0; ucode_data = 32'h1234_5678;
        start = 1'b1; start_pc = 8'd0;
        tick();
        ucode_w_v = 1'b0; start = 1'b0;
        tick();
        check("reload_pc", 64'(pc), 64'd0);
        check("reload_inst", 64'(inst), 64'h1234_5678);

        // Asynchronous reset between clock edges while an entry is valid.
        #2 reset_n = 1'b0;
        #1;
        check("areset_v", 64'(inst_v), 64'd0);
        check("areset_ready", 64'(ucode_w_ready), 64'd0);
        check("areset_pc", 64'(pc), 64'd0);
        tick();
        reset_n = 1'b1;
        tick();
        check("post_rst_ready", 64'(ucode_w_ready), 64'd1);
        check("post_rst_v", 64'(inst_v), 64'd0);
        do_start(8'd0);
        check("retain_inst0", 64'(inst), 64'h1234_5678);
        inst_yumi = 1'b1;
        tick();
        inst_yumi = 1'b0;
        check("retain_pc1", 64'(pc), 64'd1);
        check("retain_inst1", 64'(inst), 64'd1);
        do_halt();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/bp_cce_inst_fetch.md
# bp_cce_inst_fetch

Microcode fetch stage of the CCE. Holds the instruction RAM, which is loaded while the CCE is idle. Generates the sequential PC and delivers a stream of (pc, instruction) pairs through a 2-entry buffer. The consumer is the CCE decode/execute stage and the instruction tracer. Branch redirects from execute flush in-flight fetches and restart at the target.

## Interface
- bp_params_p, e_bp_default_cfg: processor config; supplies cce_pc_width_p and cce_instr_width_p; RAM depth is 2^cce_pc_width_p.
- clk_i  in  1  clock; all state updates on posedge.
- reset_n_i  in  1  reset, asynchronous, active-low.
- ucode_w_v_i  in  1  microcode write valid.
- ucode_addr_i  in  cce_pc_width_p  write address.
- ucode_data_i  in  cce_instr_width_p  write data.
- ucode_w_ready_o  out  1  write accepted this cycle when high with ucode_w_v_i.
- start_i  in  1  begin fetching (pulse).
- start_pc_i  in  cce_pc_width_p  first PC after start.
- halt_i  in  1  stop fetching, flush, return to idle.
- branch_v_i  in  1  redirect; legal only in the same cycle as inst_yumi_i.
- branch_target_i  in  cce_pc_width_p  redirect PC.
- inst_v_o  out  1  buffer head valid.
- pc_o  out  cce_pc_width_p  PC of head instruction.
- inst_o  out  bp_cce_inst_s  head instruction.
- inst_yumi_i  in  1  consumer takes head; legal only when inst_v_o.

## Operation
- States: e_idle, e_fetch. Asynchronous reset forces e_idle, fetch_pc=0, buffer empty, in-flight=0.
- e_idle:
  - ucode_w_ready_o=1; ucode_w_v_i writes the RAM at ucode_addr_i.
  - No reads; inst_v_o=0.
  - start_i: fetch_pc<=start_pc_i, go to e_fetch. Writes in the same cycle as start_i are still accepted.
- e_fetch:
  - ucode_w_ready_o=0; ucode_w_v_i is ignored.
  - Read issue: when occupancy+inflight < 2, or when inst_yumi_i is high, read RAM[fetch_pc] and set fetch_pc<=fetch_pc+1.
  - fetch_pc wraps modulo 2^cce_pc_width_p; the PC after all-ones is 0.
  - Read data arrives the next cycle and is written into the buffer together with its PC.
  - The buffer never overflows. This is guaranteed by the occupancy+inflight credit rule.
  - Buffer pops on inst_yumi_i. A push and a pop in the same cycle are both honoured.
- Branch (branch_v_i with inst_yumi_i):
  - Discard all buffer entries and the in-flight read.
  - fetch_pc<=branch_target_i.
  - A branch takes priority over a sequential issue in that cycle, so no read is issued.
- halt_i, in any state: flush the buffer and in-flight read, then go to e_idle. halt_i takes priority over branch_v_i and start_i.
- Assertions (nonsynth):
  - branch_v_i without inst_yumi_i.
  - inst_yumi_i without inst_v_o.
  - ucode_w_v_i in e_fetch.

## Timing
- Reset values: inst_v_o=0, pc_o=0, inst_o=0. ucode_w_ready_o=0 while reset_n_i is low and 1 after release (e_idle).
- start_i in cycle N: first read in N+1, inst_v_o=1 with pc_o=start_pc_i in N+2.
- Steady state with inst_yumi_i held high: one instruction per cycle and no bubbles.
- Branch in cycle N: inst_v_o=0 in N+1; target read in N+1; target valid in N+2. The branch costs exactly one bubble.
- Consumer stall: at most 2 buffered entries plus 0 in-flight. Issue resumes the same cycle inst_yumi_i returns.
- halt_i in cycle N: inst_v_o=0 and ucode_w_ready_o=1 in N+1.
- Reset mid-fetch: immediate return to the reset values. RAM contents are not cleared.

## Structure
- bp_me_pkg gets bp_cce_inst_fetch_state_e {e_idle, e_fetch}. It already contains bp_cce_inst_s.
- Sub-module: bsg_mem_1rw_sync holds the instruction RAM.
  - One port is sufficient because writes occur only in e_idle and reads only in e_fetch.
  - Width cce_instr_width_p, depth 2^cce_pc_width_p.
- The 2-entry buffer, credit counter, and PC register are inline. The buffer uses separate pc and inst arrays with 1-bit read and write pointers.

## Test plan
- Load, start, free-run: write RAM[k]=k for k=0..15; start_i with start_pc_i=0; yumi held high → pc_o 0,1,2,… with inst_o=k, one per cycle from N+2, no gaps.
- Consumer stall: after start, hold inst_yumi_i=0 for 10 cycles → exactly 2 entries buffered (pc 0,1); on release, pc 0,1,2,3 appear on consecutive cycles with no duplicates and no skips.
- Branch: yumi on pc=5 with branch_v_i and target=0x3 → inst_v_o=0 for one cycle, then pc_o=3,4,…; the stale pc 6 and 7 never appear.
- PC wrap: start_pc_i = all-ones minus 1 → pc_o sequence is max-1, max, 0, 1.
- Halt and reload: halt_i mid-stream → inst_v_o=0 and ucode_w_ready_o=1 next cycle; rewrite RAM[0]; restart at 0 → the new value is observed.
- Async reset mid-fetch: drop reset_n_i between clock edges → inst_v_o=0 immediately; after release, state is e_idle and RAM contents are retained.
